// File: rtl/goertzel_power_detect.sv
`default_nettype none
// ============================================================================
// Module   : goertzel_power_detect
// Brief    : Goertzel bin power |X|^2 pipeline with debounced tone detector.
// Revision : 1.0 - initial release
// ============================================================================
module goertzel_power_detect #(
   parameter int OW       = 20,
   parameter int PW       = 2*OW+1,
   parameter int HOLD_ON  = 3,
   parameter int HOLD_OFF = 3
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic [2*OW-1:0] s_axis_tdata,
   input  logic            s_axis_tvalid,
   output logic            s_axis_tready,
   output logic [PW-1:0]   m_axis_tdata,
   output logic            m_axis_tuser,
   output logic            m_axis_tvalid,
   input  logic            m_axis_tready,
   input  logic [PW-1:0]   i_threshold,
   output logic            o_detect
);

   localparam int c_HMAX = (HOLD_ON > HOLD_OFF) ? HOLD_ON : HOLD_OFF;
   localparam int c_CW   = $clog2(c_HMAX + 1);

   localparam logic [1:0] c_ST_IDLE = 2'd0;
   localparam logic [1:0] c_ST_ARM  = 2'd1;
   localparam logic [1:0] c_ST_ON   = 2'd2;
   localparam logic [1:0] c_ST_REL  = 2'd3;

   logic                   r_v1, r_v2, r_v3;
   logic signed [OW-1:0]   r_re, r_im;
   logic [2*OW-1:0]        r_sq_re, r_sq_im;
   logic [PW-1:0]          r_pwr;
   logic                   r_hit;
   logic signed [2*OW-1:0] w_sq_re, w_sq_im;
   logic [PW-1:0]          w_sum;
   logic                   w_hit, w_en, w_accept, w_eval;
   logic [1:0]             r_state, w_state_nxt;
   logic [c_CW-1:0]        r_cnt, w_cnt_nxt, w_cnt_inc;
   logic                   w_detect_nxt;

   // One enable for the whole pipe: everything stalls together on backpressure.
   assign w_en          = !r_v3 || m_axis_tready;
   assign w_accept      = s_axis_tvalid && w_en;
   assign w_eval        = w_en && r_v2;
   assign s_axis_tready = w_en;

   assign w_sq_re = r_re * r_re;
   assign w_sq_im = r_im * r_im;
   assign w_sum   = PW'(r_sq_re) + PW'(r_sq_im);
   assign w_hit   = (w_sum >= i_threshold);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_v1    <= 1'b0;
         r_v2    <= 1'b0;
         r_v3    <= 1'b0;
         r_re    <= '0;
         r_im    <= '0;
         r_sq_re <= '0;
         r_sq_im <= '0;
         r_pwr   <= '0;
         r_hit   <= 1'b0;
      end else if (w_en) begin
         r_v1    <= w_accept;
         r_re    <= s_axis_tdata[2*OW-1:OW];
         r_im    <= s_axis_tdata[OW-1:0];
         r_v2    <= r_v1;
         r_sq_re <= $unsigned(w_sq_re);
         r_sq_im <= $unsigned(w_sq_im);
         r_v3    <= r_v2;
         r_pwr   <= w_sum;
         r_hit   <= w_hit;
      end
   end

   assign m_axis_tdata  = r_pwr;
   assign m_axis_tuser  = r_hit;
   assign m_axis_tvalid = r_v3;

   // Debounce FSM steps once per frame, as its sum lands in the output stage.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= c_ST_IDLE;
         r_cnt    <= '0;
         o_detect <= 1'b0;
      end else if (w_eval) begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         o_detect <= w_detect_nxt;
      end
   end

   assign w_cnt_inc = r_cnt + c_CW'(1);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      case (r_state)
         c_ST_IDLE: begin
            if (w_hit) begin
               if (HOLD_ON == 1) begin
                  w_state_nxt = c_ST_ON;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = c_ST_ARM;
                  w_cnt_nxt   = c_CW'(1);
               end
            end
         end
         c_ST_ARM: begin
            if (!w_hit) begin
               w_state_nxt = c_ST_IDLE;
               w_cnt_nxt   = '0;
            end else if (w_cnt_inc == c_CW'(HOLD_ON)) begin
               w_state_nxt = c_ST_ON;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
         c_ST_ON: begin
            if (!w_hit) begin
               if (HOLD_OFF == 1) begin
                  w_state_nxt = c_ST_IDLE;
                  w_cnt_nxt   = '0;
               end else begin
                  w_state_nxt = c_ST_REL;
                  w_cnt_nxt   = c_CW'(1);
               end
            end
         end
         default: begin
            if (w_hit) begin
               w_state_nxt = c_ST_ON;
               w_cnt_nxt   = '0;
            end else if (w_cnt_inc == c_CW'(HOLD_OFF)) begin
               w_state_nxt = c_ST_IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
            end
         end
      endcase
   end

   always_comb begin
      w_detect_nxt = (w_state_nxt == c_ST_ON) || (w_state_nxt == c_ST_REL);
   end

endmodule
`default_nettype wire

// File: tb/tb_goertzel_power_detect.sv
`default_nettype none
// ============================================================================
// Module   : tb_goertzel_power_detect
// Brief    : Scoreboard bench for goertzel_power_detect (debounce 3/3 and 1/1).
// Revision : 1.0 - initial release
// ============================================================================
module tb_goertzel_power_detect;

   localparam int OW = 20;
   localparam int PW = 2*OW+1;

   logic            i_clk = 1'b0;
   logic            i_rst = 1'b1;
   logic [2*OW-1:0] s_tdata = '0;
   logic            s_tvalid = 1'b0;
   logic            m_tready = 1'b1;
   logic [PW-1:0]   thr = PW'(20);
   logic            s_tready, m_tuser, m_tvalid, det;
   logic [PW-1:0]   m_tdata;
   logic            s1_tready, m1_tuser, m1_tvalid, det1;
   logic [PW-1:0]   m1_tdata;

   always #5 i_clk = ~i_clk;

   goertzel_power_detect #(.OW(OW), .PW(PW), .HOLD_ON(3), .HOLD_OFF(3)) dut (
      .i_clk(i_clk), .i_rst(i_rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tuser(m_tuser), .m_axis_tvalid(m_tvalid),
      .m_axis_tready(m_tready), .i_threshold(thr), .o_detect(det));

   goertzel_power_detect #(.OW(OW), .PW(PW), .HOLD_ON(1), .HOLD_OFF(1)) dut1 (
      .i_clk(i_clk), .i_rst(i_rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s1_tready),
      .m_axis_tdata(m1_tdata), .m_axis_tuser(m1_tuser), .m_axis_tvalid(m1_tvalid),
      .m_axis_tready(m_tready), .i_threshold(thr), .o_detect(det1));

   typedef struct {
      longint pwr;
      bit     hit;
      bit     cd;
      bit     det;
      bit     cd1;
      bit     cl;
      longint acc;
   } exp_t;

   exp_t          q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   longint        cyc     = 0;
   bit            bp_mode = 1'b0;
   bit [3:0]      bp_pat  = 4'b1001;
   int            bp_idx  = 0;
   bit            stalled = 1'b0;
   logic [PW-1:0] held    = '0;

   always @(posedge i_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input longint got, input longint exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Output ready pattern 1,0,0,1,... while backpressure is enabled.
   always @(posedge i_clk) begin
      #1;
      if (bp_mode) begin
         m_tready = bp_pat[bp_idx];
         bp_idx   = (bp_idx + 1) % 4;
      end else begin
         m_tready = 1'b1;
      end
   end

   always @(negedge i_clk) begin
      if (i_rst) begin
         stalled = 1'b0;
      end else begin
         if (stalled && m_tvalid)
            check("hold_data", longint'(m_tdata), longint'(held));
         if (m_tvalid && !m_tready) begin
            check("bp_sready", longint'(s_tready), 0);
            check("bp_sready1", longint'(s1_tready), 0);
            stalled = 1'b1;
            held    = m_tdata;
         end else begin
            stalled = 1'b0;
         end
         if (m_tvalid && m_tready) begin
            if (q.size() == 0) begin
               check("spurious_out", 1, 0);
            end else begin
               exp_t e;
               e = q.pop_front();
               check("power", longint'(m_tdata), e.pwr);
               check("tuser", longint'(m_tuser), longint'(e.hit));
               if (e.cd) check("detect", longint'(det), longint'(e.det));
               if (e.cd1) begin
                  check("detect1", longint'(det1), longint'(e.hit));
                  check("power1", longint'(m1_tdata), e.pwr);
                  check("tuser1", longint'(m1_tuser), longint'(e.hit));
                  check("valid1", longint'(m1_tvalid), 1);
               end
               if (e.cl) check("latency", cyc - e.acc, 3);
            end
         end
      end
   end

   task automatic send(input int re, input int im, input bit cd = 1'b0, input bit d = 1'b0,
                       input bit cd1 = 1'b0, input bit cl = 1'b0);
      exp_t e;
      bit   done;
      done     = 1'b0;
      s_tdata  = {re[OW-1:0], im[OW-1:0]};
      s_tvalid = 1'b1;
      e.pwr    = longint'(re) * longint'(re) + longint'(im) * longint'(im);
      e.hit    = (e.pwr >= longint'(thr));
      e.cd     = cd;
      e.det    = d;
      e.cd1    = cd1;
      e.cl     = cl;
      e.acc    = 0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge i_clk);
         if (s_tready) begin
            e.acc = cyc;
            q.push_back(e);
            done  = 1'b1;
         end
         @(posedge i_clk); #1;
      end
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      s_tvalid = 1'b0;
      for (int k = 0; k < 200; k++) begin
         if (q.size() == 0) break;
         @(posedge i_clk); #1;
      end
      check("drain", longint'(q.size()), 0);
   endtask

   task automatic do_reset();
      i_rst    = 1'b1;
      s_tvalid = 1'b0;
      @(posedge i_clk); #1;
      i_rst = 1'b0;
      q.delete();
   endtask

   initial begin
      int hi_pat [12] = '{1,1,0,1,1,1,0,0,1,0,0,0};
      int det_pat[12] = '{0,0,0,0,0,1,1,1,1,1,1,0};
      repeat (2) @(posedge i_clk);
      #1 i_rst = 1'b0;
      @(negedge i_clk);
      check("rst_sready", longint'(s_tready), 1);
      check("rst_mvalid", longint'(m_tvalid), 0);
      check("rst_tdata", longint'(m_tdata), 0);
      check("rst_tuser", longint'(m_tuser), 0);
      check("rst_detect", longint'(det), 0);
      @(posedge i_clk); #1;

      // basic power, latency and extreme operands
      send(3, 4, 0, 0, 0, 1);
      drain();
      send(-524288, -524288);
      send(0, -1);
      drain();

      // continuous stream under toggling backpressure
      bp_mode = 1'b1;
      for (int i = 0; i < 8; i++) send(i + 1, -(2*i + 3));
      drain();
      bp_mode = 1'b0;

      // debounce sequence: 200 is a hit, 50 a miss against 100
      do_reset();
      thr = PW'(100);
      for (int i = 0; i < 12; i++)
         send(hi_pat[i] ? 10 : 5, hi_pat[i] ? 10 : 5, 1'b1, det_pat[i][0], 1'b1, 1'b0);
      drain();

      // bring detect high, then reset with two frames in flight
      for (int i = 0; i < 3; i++) send(10, 10, 1'b1, (i == 2), 1'b1, 1'b0);
      drain();
      s_tdata  = {20'd7, 20'd7};
      s_tvalid = 1'b1;
      @(posedge i_clk); #1;
      s_tdata  = {20'd9, 20'd9};
      @(posedge i_clk); #1;
      s_tvalid = 1'b0;
      do_reset();
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         check("flight_mvalid", longint'(m_tvalid), 0);
         check("flight_detect", longint'(det), 0);
      end
      @(posedge i_clk); #1;
      send(3, 4, 1'b1, 1'b0, 1'b0, 1'b1);
      drain();

      // zero threshold: every frame is a hit, 1-frame debounce fires at once
      do_reset();
      thr = '0;
      send(0, 0, 1'b1, 1'b0, 1'b1, 1'b0);
      drain();

      repeat (3) @(posedge i_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
